// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// State encodings are fixed because State is exported for debug.
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_REXEC   = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_IEXEC   = 4'd10,
        S_IWB     = 4'd11,
        S_TRAP    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic mem;
        logic rtype;
        logic branch;
        logic jump;
        logic imm;
        logic illegal;
    } iclass_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational instruction classifier: opcode/funct to a one-hot class.
// store_o qualifies the mem class (SW vs LW).
module instr_class_decode
    import control_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    output iclass_t             class_o,
    output logic                store_o
);

    logic funct_ok;

    always_comb begin
        funct_ok = (funct_i == FUNCT_W'(FN_ADD)) || (funct_i == FUNCT_W'(FN_SUB)) ||
                   (funct_i == FUNCT_W'(FN_AND)) || (funct_i == FUNCT_W'(FN_OR))  ||
                   (funct_i == FUNCT_W'(FN_SLT));
    end

    always_comb begin
        class_o = '0;
        store_o = 1'b0;
        if (opcode_i == OPCODE_W'(OP_LW)) begin
            class_o.mem = 1'b1;
        end else if (opcode_i == OPCODE_W'(OP_SW)) begin
            class_o.mem = 1'b1;
            store_o     = 1'b1;
        end else if (opcode_i == OPCODE_W'(OP_RTYPE) && funct_ok) begin
            class_o.rtype = 1'b1;
        end else if (opcode_i == OPCODE_W'(OP_BEQ)) begin
            class_o.branch = 1'b1;
        end else if (opcode_i == OPCODE_W'(OP_J)) begin
            class_o.jump = 1'b1;
        end else if (opcode_i == OPCODE_W'(OP_ADDI)) begin
            class_o.imm = 1'b1;
        end else begin
            class_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control FSM: Moore decode of the state register, with
// optional MemReady gating in the memory states.
module multicycle_control_fsm
    import control_pkg::*;
#(
    parameter int OPCODE_W      = 6,
    parameter int FUNCT_W       = 6,
    parameter int MEM_HANDSHAKE = 0,
    parameter int ILLEGAL_TRAP  = 0
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic [FUNCT_W-1:0]  Funct,
    input  logic                MemReady,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemToReg,
    output logic                IRWrite,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          PCSource,
    output logic                InstrDone,
    output logic                Illegal,
    output logic [3:0]          State
);

    state_e  state_q, state_d;
    logic    store_q, store_d;
    iclass_t cls;
    logic    cls_store;
    logic    ready;

    instr_class_decode #(.OPCODE_W(OPCODE_W), .FUNCT_W(FUNCT_W)) u_decode (
        .opcode_i (Opcode),
        .funct_i  (Funct),
        .class_o  (cls),
        .store_o  (cls_store)
    );

    assign ready = (MEM_HANDSHAKE == 0) || MemReady;
    assign State = state_q;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALUOP_ADD;
        PCSource    = 2'b00;
        InstrDone   = 1'b0;
        Illegal     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                // IR/PC commit only on the completing beat so PC bumps once per fetch
                MemRead = 1'b1;
                IRWrite = ready;
                PCWrite = ready;
                ALUSrcB = 2'b01;
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                store_d = cls_store;
                if (cls.mem)         state_d = S_MEMADDR;
                else if (cls.rtype)  state_d = S_REXEC;
                else if (cls.branch) state_d = S_BRANCH;
                else if (cls.jump)   state_d = S_JUMP;
                else if (cls.imm)    state_d = S_IEXEC;
                else begin
                    Illegal = 1'b1;
                    state_d = (ILLEGAL_TRAP != 0) ? S_TRAP : S_FETCH;
                end
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = store_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                MemToReg  = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                InstrDone = ready;
                if (ready) state_d = S_FETCH;
            end
            S_REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                InstrDone   = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_IWB;
            end
            S_IWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: three parameterisations share one set of
// inputs; directed tables, corner sequences and a plan-based random model.
module tb_multicycle_control_fsm;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       MemReady = 1'b0;
    logic [5:0] Opcode = 6'h00;
    logic [5:0] Funct = 6'h20;

    always #5 Clk = ~Clk;

    // Output vector layout:
    // [17]IorD [16]MemRead [15]MemWrite [14]MemToReg [13]IRWrite [12]RegDst
    // [11]RegWrite [10]ALUSrcA [9]PCWrite [8]PCWriteCond [7:6]ALUSrcB
    // [5:4]ALUOp [3:2]PCSource [1]InstrDone [0]Illegal
    logic [17:0] ov0, ov1, ov2;
    logic [3:0]  st0, st1, st2;

    multicycle_control_fsm #(.OPCODE_W(6), .FUNCT_W(6), .MEM_HANDSHAKE(0), .ILLEGAL_TRAP(0)) dut0 (
        .Clk(Clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .MemReady(MemReady),
        .IorD(ov0[17]), .MemRead(ov0[16]), .MemWrite(ov0[15]), .MemToReg(ov0[14]),
        .IRWrite(ov0[13]), .RegDst(ov0[12]), .RegWrite(ov0[11]), .ALUSrcA(ov0[10]),
        .PCWrite(ov0[9]), .PCWriteCond(ov0[8]), .ALUSrcB(ov0[7:6]), .ALUOp(ov0[5:4]),
        .PCSource(ov0[3:2]), .InstrDone(ov0[1]), .Illegal(ov0[0]), .State(st0));

    multicycle_control_fsm #(.OPCODE_W(6), .FUNCT_W(6), .MEM_HANDSHAKE(1), .ILLEGAL_TRAP(0)) dut1 (
        .Clk(Clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .MemReady(MemReady),
        .IorD(ov1[17]), .MemRead(ov1[16]), .MemWrite(ov1[15]), .MemToReg(ov1[14]),
        .IRWrite(ov1[13]), .RegDst(ov1[12]), .RegWrite(ov1[11]), .ALUSrcA(ov1[10]),
        .PCWrite(ov1[9]), .PCWriteCond(ov1[8]), .ALUSrcB(ov1[7:6]), .ALUOp(ov1[5:4]),
        .PCSource(ov1[3:2]), .InstrDone(ov1[1]), .Illegal(ov1[0]), .State(st1));

    multicycle_control_fsm #(.OPCODE_W(6), .FUNCT_W(6), .MEM_HANDSHAKE(0), .ILLEGAL_TRAP(1)) dut2 (
        .Clk(Clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .MemReady(MemReady),
        .IorD(ov2[17]), .MemRead(ov2[16]), .MemWrite(ov2[15]), .MemToReg(ov2[14]),
        .IRWrite(ov2[13]), .RegDst(ov2[12]), .RegWrite(ov2[11]), .ALUSrcA(ov2[10]),
        .PCWrite(ov2[9]), .PCWriteCond(ov2[8]), .ALUSrcB(ov2[7:6]), .ALUOp(ov2[5:4]),
        .PCSource(ov2[3:2]), .InstrDone(ov2[1]), .Illegal(ov2[0]), .State(st2));

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 'h%0h want 'h%0h", nm, act, exp);
        end
    endtask

    function automatic logic [17:0] get_ov(input int d);
        return (d == 0) ? ov0 : (d == 1) ? ov1 : ov2;
    endfunction

    function automatic logic [3:0] get_st(input int d);
        return (d == 0) ? st0 : (d == 1) ? st1 : st2;
    endfunction

    function automatic bit legal_instr(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
        return (op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02 || op == 6'h08);
    endfunction

    // Control values listed per state; rdy already folds in the handshake option.
    function automatic logic [17:0] ref_out(input int s, input bit rdy, input bit ill);
        logic iord = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0, rdst = 0, rw = 0;
        logic asa = 0, pcw = 0, pcc = 0, done = 0, il = 0;
        logic [1:0] asb = 0, aop = 0, psrc = 0;
        case (s)
            0:  begin mrd = 1; irw = rdy; asb = 2'b01; pcw = rdy; end
            1:  begin asb = 2'b11; il = ill; end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; done = 1; end
            5:  begin mwr = 1; iord = 1; done = rdy; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rdst = 1; rw = 1; done = 1; end
            8:  begin asa = 1; aop = 2'b01; pcc = 1; psrc = 2'b01; done = 1; end
            9:  begin pcw = 1; psrc = 2'b10; done = 1; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; done = 1; end
            default: ;
        endcase
        return {iord, mrd, mwr, m2r, irw, rdst, rw, asa, pcw, pcc, asb, aop, psrc, done, il};
    endfunction

    task automatic do_reset();
        @(negedge Clk); reset = 1'b1;
        @(negedge Clk); reset = 1'b0;
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] st;
        logic       done;
    } vec_t;
    vec_t tbl[$];

    task automatic v(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] s, input logic d);
        vec_t e;
        e.op = op; e.fn = fn; e.st = s; e.done = d;
        tbl.push_back(e);
    endtask

    task automatic rand_phase(input int d, input bit hs, input bit tr, input int ncyc);
        int ms;
        int plan[$];
        bit rdy;
        logic [5:0] ops[8];
        logic [5:0] fns[6];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h11};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
        do_reset();
        ms = 0;
        for (int c = 0; c < ncyc; c++) begin
            Opcode   = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            Funct    = fns[$urandom_range(0, 5)];
            MemReady = $urandom_range(0, 2) != 0;
            #1;
            rdy = !hs || MemReady;
            chk($sformatf("rand d%0d c%0d state", d, c), 32'(get_st(d)), 32'(ms));
            chk($sformatf("rand d%0d c%0d outs", d, c), 32'(get_ov(d)),
                32'(ref_out(ms, rdy, !legal_instr(Opcode, Funct))));
            if (ms == 0) begin
                if (rdy) ms = 1;
            end else if (ms == 1) begin
                plan.delete();
                if (!legal_instr(Opcode, Funct)) begin
                    if (tr) plan.push_back(12);
                end else case (Opcode)
                    6'h23: begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
                    6'h2B: begin plan.push_back(2); plan.push_back(5); end
                    6'h00: begin plan.push_back(6); plan.push_back(7); end
                    6'h04: plan.push_back(8);
                    6'h02: plan.push_back(9);
                    default: begin plan.push_back(10); plan.push_back(11); end
                endcase
                ms = (plan.size() > 0) ? plan.pop_front() : 0;
            end else if (ms == 12) begin
                ms = 12;
            end else if ((ms == 3 || ms == 5) && !rdy) begin
                ms = ms;
            end else begin
                ms = (plan.size() > 0) ? plan.pop_front() : 0;
            end
            @(negedge Clk);
        end
    endtask

    int ndone;

    initial begin
        // Directed instruction stream on dut0: ADD, LW, SW, BEQ, J, ADDI
        v(6'h00, 6'h20, 0, 0); v(6'h00, 6'h20, 1, 0); v(6'h00, 6'h20, 6, 0); v(6'h00, 6'h20, 7, 1);
        v(6'h23, 6'h00, 0, 0); v(6'h23, 6'h00, 1, 0); v(6'h23, 6'h00, 2, 0); v(6'h23, 6'h00, 3, 0);
        v(6'h23, 6'h00, 4, 1);
        v(6'h2B, 6'h00, 0, 0); v(6'h2B, 6'h00, 1, 0); v(6'h2B, 6'h00, 2, 0); v(6'h2B, 6'h00, 5, 1);
        v(6'h04, 6'h00, 0, 0); v(6'h04, 6'h00, 1, 0); v(6'h04, 6'h00, 8, 1);
        v(6'h02, 6'h00, 0, 0); v(6'h02, 6'h00, 1, 0); v(6'h02, 6'h00, 9, 1);
        v(6'h08, 6'h00, 0, 0); v(6'h08, 6'h00, 1, 0); v(6'h08, 6'h00, 10, 0); v(6'h08, 6'h00, 11, 1);

        do_reset();
        #1;
        chk("reset state", 32'(st0), 32'd0);
        chk("reset outs", 32'(ov0), 32'h12240);
        chk("reset outs hs ready0", 32'(ov1), 32'h10040);

        ndone = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            Opcode = tbl[i].op; Funct = tbl[i].fn; MemReady = 1'b0;
            #1;
            chk($sformatf("seq %0d state", i), 32'(st0), 32'(tbl[i].st));
            chk($sformatf("seq %0d done", i), 32'(ov0[1]), 32'(tbl[i].done));
            ndone += int'(ov0[1]);
            @(negedge Clk);
        end
        chk("seq done count", 32'(ndone), 32'd6);

        // Reset while in MEMRD of an LW
        do_reset();
        Opcode = 6'h23;
        repeat (3) @(negedge Clk);
        #1 chk("midLW in MEMRD", 32'(st0), 32'd3);
        reset = 1'b1;
        @(negedge Clk); reset = 1'b0;
        #1;
        chk("midLW reset state", 32'(st0), 32'd0);
        chk("midLW reset outs", 32'(ov0), 32'h12240);

        // Handshake waits in FETCH and MEMRD on dut1
        do_reset();
        Opcode = 6'h23; Funct = 6'h00;
        for (int k = 0; k < 4; k++) begin
            MemReady = (k == 3);
            #1;
            chk($sformatf("hs fetch %0d state", k), 32'(st1), 32'd0);
            chk($sformatf("hs fetch %0d memread", k), 32'(ov1[16]), 32'd1);
            chk($sformatf("hs fetch %0d pcwrite", k), 32'(ov1[9]), 32'(k == 3));
            chk($sformatf("hs fetch %0d irwrite", k), 32'(ov1[13]), 32'(k == 3));
            @(negedge Clk);
        end
        MemReady = 1'b0;
        #1 chk("hs decode", 32'(st1), 32'd1);
        @(negedge Clk);
        #1 chk("hs memaddr", 32'(st1), 32'd2);
        @(negedge Clk);
        for (int k = 0; k < 4; k++) begin
            MemReady = (k == 3);
            #1;
            chk($sformatf("hs memrd %0d state", k), 32'(st1), 32'd3);
            chk($sformatf("hs memrd %0d rd/iord", k), 32'({ov1[17], ov1[16]}), 32'd3);
            @(negedge Clk);
        end
        MemReady = 1'b0;
        #1 chk("hs memwb", 32'(st1), 32'd4);
        chk("hs memwb done", 32'(ov1[1]), 32'd1);

        // Illegal opcode without trap
        do_reset();
        Opcode = 6'h3F;
        @(negedge Clk);
        #1;
        chk("illegal decode", 32'(st0), 32'd1);
        chk("illegal flag", 32'(ov0[0]), 32'd1);
        chk("illegal no done", 32'(ov0[1]), 32'd0);
        @(negedge Clk);
        #1;
        chk("illegal back to fetch", 32'(st0), 32'd0);
        chk("illegal fetch no done", 32'(ov0[1]), 32'd0);

        // Illegal funct with trap on dut2
        do_reset();
        Opcode = 6'h00; Funct = 6'h21;
        @(negedge Clk);
        #1 chk("trap illegal flag", 32'(ov2[0]), 32'd1);
        @(negedge Clk);
        for (int k = 0; k < 10; k++) begin
            Opcode = 6'($urandom); MemReady = $urandom_range(0, 1) != 0;
            #1;
            chk($sformatf("trap %0d state", k), 32'(st2), 32'd12);
            chk($sformatf("trap %0d outs", k), 32'(ov2), 32'd0);
            @(negedge Clk);
        end
        reset = 1'b1;
        @(negedge Clk); reset = 1'b0;
        #1 chk("trap reset", 32'(st2), 32'd0);

        // SW: reset and MemReady together in MEMWR on dut1
        do_reset();
        Opcode = 6'h2B; MemReady = 1'b1;
        repeat (3) @(negedge Clk);
        MemReady = 1'b0;
        #1;
        chk("sw memwr state", 32'(st1), 32'd5);
        chk("sw memwr wait", 32'({ov1[17], ov1[15], ov1[1]}), 32'b110);
        @(negedge Clk);
        MemReady = 1'b1; reset = 1'b1;
        #1;
        chk("sw memwr ready", 32'({ov1[15], ov1[1]}), 32'b11);
        @(negedge Clk); reset = 1'b0; MemReady = 1'b0;
        #1;
        chk("sw reset state", 32'(st1), 32'd0);
        chk("sw no 2nd write", 32'(ov1[15]), 32'd0);

        rand_phase(1, 1'b1, 1'b0, 400);
        rand_phase(0, 1'b0, 1'b0, 300);
        rand_phase(2, 1'b0, 1'b1, 60);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Parametrised multicycle MIPS control unit driving the shared-memory datapath (single memory, IR, A/B/ALUOut registers). It replaces the flat opcode decoder with an explicit per-instruction state sequence (Fetch → Decode → Execute → Memory → Writeback), adds BEQ and extra R-type functions, and adds an optional memory-ready handshake. It also detects illegal instructions with a selectable trap mode and emits an instruction-retire pulse for the bench and performance counters.

## Interface
- OPCODE_W, 6, opcode field width
- FUNCT_W, 6, funct field width
- MEM_HANDSHAKE, 0, 0: memory always completes in 1 cycle (MemReady ignored); 1: memory states wait for MemReady
- ILLEGAL_TRAP, 0, 0: illegal instruction returns to FETCH; 1: enters TRAP until reset
- Clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high; forces FETCH
- Opcode  in  OPCODE_W  IR[31:26]; sampled only in DECODE
- Funct  in  FUNCT_W  IR[5:0]; sampled only in DECODE
- MemReady  in  1  memory access complete this cycle
- IorD, MemRead, MemWrite, MemToReg, IRWrite, RegDst, RegWrite, ALUSrcA, PCWrite, PCWriteCond  out  1  datapath controls
- ALUSrcB, ALUOp, PCSource  out  2  datapath selects
- InstrDone  out  1  one-cycle pulse in the last cycle of each legal instruction
- Illegal  out  1  high in the DECODE cycle that sees an unsupported opcode or funct
- State  out  4  current state encoding, for debug

## Operation
- Outputs are Moore decodes of the state register. The only exception is gating by MemReady in memory states when MEM_HANDSHAKE=1.
- Every output not listed for a state is 0.
- FETCH(0): MemRead=1, IRWrite=1, ALUSrcB=01, ALUOp=00, PCWrite=1, PCSource=00 → DECODE.
- DECODE(1): ALUSrcB=11, ALUOp=00. Next state by Opcode:
  - 0x23 or 0x2B → MEMADDR
  - 0x00 with legal funct → REXEC
  - 0x04 → BRANCH
  - 0x02 → JUMP
  - 0x08 → IEXEC
  - anything else → Illegal=1, then FETCH or TRAP
- Legal funct values: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
- MEMADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00 → MEMRD if 0x23, MEMWR if 0x2B.
- MEMRD(3): MemRead=1, IorD=1 → MEMWB.
- MEMWB(4): RegWrite=1, MemToReg=1, RegDst=0, InstrDone=1 → FETCH.
- MEMWR(5): MemWrite=1, IorD=1, InstrDone=1 → FETCH.
- REXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 → RWB.
- RWB(7): RegDst=1, RegWrite=1, InstrDone=1 → FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, InstrDone=1 → FETCH.
- JUMP(9): PCWrite=1, PCSource=10, InstrDone=1 → FETCH.
- IEXEC(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00 → IWB.
- IWB(11): RegWrite=1, RegDst=0, MemToReg=0, InstrDone=1 → FETCH.
- TRAP(12): all outputs 0; held until reset. Encodings 13–15 are unreachable and go to FETCH.

## Timing
- Reset: on the first edge with reset=1, State=0 (FETCH), whatever the state was, including mid-instruction or in TRAP.
- Reset output values are the FETCH values: MemRead=1, IRWrite=1, ALUSrcB=01, PCWrite=1, all others 0. With MEM_HANDSHAKE=1, IRWrite and PCWrite equal MemReady.
- Latency with no wait: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3 cycles. Illegal takes 2 cycles (FETCH, DECODE).
- Handshake (MEM_HANDSHAKE=1):
  - FETCH, MEMRD and MEMWR hold while MemReady=0.
  - MemRead/MemWrite and IorD stay asserted and stable throughout the wait.
  - IRWrite and PCWrite in FETCH are asserted only when MemReady=1, so PC increments exactly once per fetch.
  - MEMWR asserts InstrDone only in the MemReady=1 cycle.
- MemReady arriving outside a memory state is ignored.
- Opcode/Funct changing outside DECODE has no effect.
- reset has priority over MemReady in the same cycle.

## Structure
- Package control_pkg holds:
  - state enumeration with the fixed 4-bit encodings above
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - funct constants
  - ALUOp codes ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
- One sub-module, instr_class_decode: combinational mapping of Opcode/Funct to a one-hot class (mem, rtype, branch, jump, imm, illegal). The FSM consumes only the class.

## Test plan
- Reset mid-LW (in MEMRD) → next cycle State=0, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- Sequence ADD (0x00/0x20), LW (0x23), SW (0x2B), BEQ (0x04), J (0x02), ADDI (0x08), MEM_HANDSHAKE=0:
  - required state traces 0-1-6-7, 0-1-2-3-4, 0-1-2-5, 0-1-8, 0-1-9, 0-1-10-11
  - InstrDone pulses once per instruction, 6 total
- MEM_HANDSHAKE=1, MemReady low for 3 cycles in FETCH and in MEMRD:
  - each of those states holds 4 cycles with MemRead=1 throughout
  - PCWrite high only in the final FETCH cycle
- Opcode 0x3F, ILLEGAL_TRAP=0 → Illegal=1 in DECODE, then FETCH, InstrDone never asserted.
- Opcode 0x00 with Funct 0x21, ILLEGAL_TRAP=1 → TRAP (12) with all outputs 0 for 10 cycles; reset returns to FETCH.
- SW with MemReady=1 and reset=1 in the same MEMWR cycle → State=0 next cycle, InstrDone follows MemReady in that cycle, no second MemWrite cycle.
